// File: rtl/uart_pkg.sv
// Shared definitions for the serial link transmitter and receiver.
package uart_pkg;

  typedef enum logic {IDLE, TRANSMIT} tx_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled, ticks on the last count.
module uart_baud_cnt #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Counter wraps on its own at the end of each bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (clr) begin
      r_cnt <= {CW{1'b0}};
    end else if (en) begin
      if (r_cnt == LAST) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; the line is the LSB of a shift register that idles all ones.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  tx_state_t                r_state;
  tx_state_t                w_state_nxt;
  logic [FRAME_BITS-1:0]    r_shift;
  logic [3:0]               r_bit_cnt;
  logic                     r_done;
  logic                     w_tick;
  logic                     w_load;
  logic                     w_frame_end;
  logic                     w_busy;

  assign w_busy = (r_state == TRANSMIT);

  uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!w_busy),
    .en    (w_busy),
    .tick  (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus one-cycle load and frame-end strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (trmt) begin
          w_load      = 1'b1;
          w_state_nxt = TRANSMIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      TRANSMIT: begin
        if (w_tick && (r_bit_cnt == LAST_BIT)) begin
          w_frame_end = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = TRANSMIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: ones shift in behind the frame so the line returns high by itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= {FRAME_BITS{1'b1}};
      r_bit_cnt <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      if (w_load) begin
        r_shift <= {1'b1, tx_data, 1'b0};
      end else if (w_busy && w_tick) begin
        r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
      end else begin
        r_shift <= r_shift;
      end

      if (w_load || w_frame_end) begin
        r_bit_cnt <= 4'd0;
      end else if (w_busy && w_tick) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end else begin
        r_bit_cnt <= r_bit_cnt;
      end

      // Clear wins over set, though the two never coincide in practice
      if (w_load) begin
        r_done <= 1'b0;
      end else if (w_frame_end) begin
        r_done <= 1'b1;
      end else begin
        r_done <= r_done;
      end
    end
  end

  assign TX      = r_shift[0];
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at BAUD_DIV=16: stimulus queues expected bytes, a line monitor decodes frames.
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       tx_done;

  int         total = 0;
  int         bad   = 0;
  int         rises = 0;
  bit         mon_en;
  bit         prev_done = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx #(.BAUD_DIV(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Counts rising edges of tx_done
  always @(negedge clk) begin
    if (tx_done && !prev_done) rises++;
    prev_done = tx_done;
  end

  // Line monitor: offset 0 is the first negedge showing the start bit
  initial begin : monitor
    logic [9:0] fr;
    logic [7:0] expb;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && TX == 1'b0) begin
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          fr[k] = TX;
          if (k < 9) repeat (16) @(negedge clk);
        end
        repeat (7) @(negedge clk);
        chk("done_before_end", tx_done, 0);
        @(negedge clk);
        chk("done_rise_160", tx_done, 1);
        chk("gap_idle_high", TX, 1);
        chk("start_bit", fr[0], 0);
        chk("stop_bit", fr[9], 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", fr[8:1], 256);
        end else begin
          expb = exp_q.pop_front();
          chk("frame_byte", fr[8:1], expb);
        end
      end
    end
  end

  // Raise trmt for one accepting edge; returns at the negedge after acceptance (offset 0)
  task automatic start_frame(input logic [7:0] d, input bit expect_it);
    tx_data = d;
    trmt    = 1'b1;
    if (expect_it) exp_q.push_back(d);
    @(negedge clk);
    trmt = 1'b0;
  endtask

  initial begin : stim
    int r0;
    bit ok;
    trmt    = 1'b0;
    tx_data = 8'h00;
    mon_en  = 1'b1;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", TX, 1);
    chk("reset_done", tx_done, 0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (TX !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_reset", ok, 1);

    // Single byte
    r0 = rises;
    start_frame(8'hA5, 1'b1);
    repeat (170) @(negedge clk);
    chk("a5_done_rises", rises - r0, 1);

    // Request while busy is ignored
    r0 = rises;
    start_frame(8'h0F, 1'b1);
    repeat (50) @(negedge clk);
    start_frame(8'hFF, 1'b0);
    repeat (300) @(negedge clk);
    chk("busy_done_rises", rises - r0, 1);

    // Back-to-back with trmt held high
    r0 = rises;
    tx_data = 8'h00;
    trmt    = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge clk);
    tx_data = 8'hFF;
    exp_q.push_back(8'hFF);
    repeat (161) @(negedge clk);
    chk("b2b_done_one_cycle", tx_done, 0);
    chk("b2b_next_start", TX, 0);
    trmt = 1'b0;
    repeat (170) @(negedge clk);
    chk("b2b_done_rises", rises - r0, 2);

    // tx_done holds through idle and clears on the accepting edge
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_done !== 1'b1) ok = 1'b0;
    end
    chk("done_holds_idle", ok, 1);
    tx_data = 8'h5A;
    trmt    = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk);
    #1;
    chk("done_clear_edge", tx_done, 0);
    chk("clear_start_bit", TX, 0);
    @(negedge clk);
    trmt = 1'b0;
    repeat (170) @(negedge clk);

    // Mid-frame asynchronous reset
    mon_en = 1'b0;
    start_frame(8'h55, 1'b0);
    repeat (70) @(negedge clk);
    chk("pre_reset_line_low", TX, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", TX, 1);
    chk("async_reset_done", tx_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", TX, 1);
    mon_en = 1'b1;
    r0 = rises;
    start_frame(8'h3C, 1'b1);
    repeat (170) @(negedge clk);
    chk("3c_done_rises", rises - r0, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
